// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- pipeline hazard/stall controller interface.
// Carries the ID/EX hazard inputs and the stall/flush/multiply-divide status
// outputs between the pipeline datapath and pipe_ctrl.
//   master modport : the controller (pipe_ctrl) -- drives stall, ex_bubble,
//                    flush, md_done, md_busy, stall_cycles.
//   slave modport  : the pipeline datapath -- drives the ID read ports, the
//                    EX load/write/mul-div indications and flush_req.
interface pipe_ctrl_if;
  logic        id_read_en_1;
  logic        id_read_en_2;
  logic [4:0]  id_read_addr_1;
  logic [4:0]  id_read_addr_2;
  logic        ex_load;
  logic        ex_write_reg_en;
  logic [4:0]  ex_write_reg_addr;
  logic        ex_md_start;
  logic        ex_md_div;
  logic        flush_req;
  logic [5:0]  stall;
  logic        ex_bubble;
  logic        flush;
  logic        md_done;
  logic        md_busy;
  logic [15:0] stall_cycles;

  modport master (
    input  id_read_en_1, id_read_en_2, id_read_addr_1, id_read_addr_2,
    input  ex_load, ex_write_reg_en, ex_write_reg_addr,
    input  ex_md_start, ex_md_div, flush_req,
    output stall, ex_bubble, flush, md_done, md_busy, stall_cycles
  );

  modport slave (
    output id_read_en_1, id_read_en_2, id_read_addr_1, id_read_addr_2,
    output ex_load, ex_write_reg_en, ex_write_reg_addr,
    output ex_md_start, ex_md_div, flush_req,
    input  stall, ex_bubble, flush, md_done, md_busy, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard controller.
// Resolves, in priority order, flush requests, multi-cycle multiply/divide
// occupancy of EX, and load-use hazards into per-stage hold signals.
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : pipe_ctrl_if.master (hazard inputs, stall/flush/md status outputs)
// stall bits: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
module pipe_ctrl #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 34
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.master bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // The first EX cycle is spent in IDLE and the last (md_done) cycle at
  // cnt == 0, so the counter is loaded with the residency minus two.
  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 2);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 2);

  localparam logic [5:0] STALL_MD   = 6'b001111;
  localparam logic [5:0] STALL_LOAD = 6'b000111;

  state_t      state_r;
  logic [5:0]  cnt_r;
  logic        hazard_s;

  // A load writing r0 never creates a dependency.
  function automatic logic load_use(
    input logic       load,
    input logic       wen,
    input logic [4:0] waddr,
    input logic       ren1,
    input logic [4:0] raddr1,
    input logic       ren2,
    input logic [4:0] raddr2
  );
    return load & wen & (waddr != 5'd0) &
           ((ren1 & (raddr1 == waddr)) | (ren2 & (raddr2 == waddr)));
  endfunction

  // Load-use hazard detection between the EX load and the ID read ports.
  always_comb begin
    hazard_s = load_use(bus.ex_load, bus.ex_write_reg_en, bus.ex_write_reg_addr,
                        bus.id_read_en_1, bus.id_read_addr_1,
                        bus.id_read_en_2, bus.id_read_addr_2);
  end

  // Multiply/divide FSM and occupancy down-counter; flush aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
    end else if (bus.flush_req) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.ex_md_start) begin
            state_r <= MD_BUSY;
            cnt_r   <= bus.ex_md_div ? DIV_LOAD : MULT_LOAD;
          end else begin
            state_r <= IDLE;
            cnt_r   <= 6'd0;
          end
        end
        MD_BUSY: begin
          if (cnt_r != 6'd0) begin
            state_r <= MD_BUSY;
            cnt_r   <= cnt_r - 6'd1;
          end else begin
            state_r <= IDLE;
            cnt_r   <= 6'd0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 6'd0;
        end
      endcase
    end
  end

  // Same-cycle control outputs; forced to zero while reset is asserted so
  // that a reset between edges silences the pipeline immediately.
  always_comb begin
    bus.stall     = 6'd0;
    bus.ex_bubble = 1'b0;
    bus.flush     = 1'b0;
    bus.md_done   = 1'b0;
    if (rst) begin
      bus.stall = 6'd0;
    end else if (bus.flush_req) begin
      bus.flush = 1'b1;
    end else if (state_r == MD_BUSY) begin
      if (cnt_r != 6'd0) begin
        bus.stall = STALL_MD;
      end else begin
        bus.md_done = 1'b1;
      end
    end else if (bus.ex_md_start) begin
      bus.stall = STALL_MD;
    end else if (hazard_s) begin
      bus.stall     = STALL_LOAD;
      bus.ex_bubble = 1'b1;
    end else begin
      bus.stall = 6'd0;
    end
  end

  assign bus.md_busy = (state_r == MD_BUSY);

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.stall_cycles <= 16'd0;
    end else if (bus.stall[0] && (bus.stall_cycles != 16'hFFFF)) begin
      bus.stall_cycles <= bus.stall_cycles + 16'd1;
    end else begin
      bus.stall_cycles <= bus.stall_cycles;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl
// (MULT_CYCLES = 4, DIV_CYCLES = 34). Inputs change just after the falling
// edge; outputs are checked 1 ns later, well away from the rising edge.
module tb_pipe_ctrl;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  pipe_ctrl_if bus();

  pipe_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(34)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.id_read_en_1      = 1'b0;
    bus.id_read_en_2      = 1'b0;
    bus.id_read_addr_1    = 5'd0;
    bus.id_read_addr_2    = 5'd0;
    bus.ex_load           = 1'b0;
    bus.ex_write_reg_en   = 1'b0;
    bus.ex_write_reg_addr = 5'd0;
    bus.ex_md_start       = 1'b0;
    bus.ex_md_div         = 1'b0;
    bus.flush_req         = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] waddr, input logic [4:0] raddr2);
    bus.ex_load           = 1'b1;
    bus.ex_write_reg_en   = 1'b1;
    bus.ex_write_reg_addr = waddr;
    bus.id_read_en_2      = 1'b1;
    bus.id_read_addr_2    = raddr2;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clear_inputs();
    rst = 1'b1;

    // Reset: outputs stay zero even when inputs request action.
    next_cycle();
    bus.flush_req   = 1'b1;
    bus.ex_md_start = 1'b1;
    set_load(5'd5, 5'd5);
    #1;
    check("rst_stall", 32'(bus.stall), 32'h0);
    check("rst_flush", 32'(bus.flush), 32'h0);
    check("rst_bubble", 32'(bus.ex_bubble), 32'h0);
    check("rst_busy", 32'(bus.md_busy), 32'h0);
    check("rst_cycles", 32'(bus.stall_cycles), 32'h0);
    clear_inputs();
    next_cycle();
    rst = 1'b0;

    // Idle, nothing active.
    next_cycle();
    check("idle_stall", 32'(bus.stall), 32'h0);
    check("idle_done", 32'(bus.md_done), 32'h0);

    // Multiply: 3 stall cycles then md_done.
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      bus.ex_md_start = 1'b1;
      bus.ex_md_div   = 1'b0;
      #1;
      check($sformatf("mul_stall_%0d", i), 32'(bus.stall), (i < 4) ? 32'h0F : 32'h0);
      check($sformatf("mul_done_%0d", i), 32'(bus.md_done), (i == 4) ? 32'h1 : 32'h0);
      check($sformatf("mul_busy_%0d", i), 32'(bus.md_busy), (i >= 2) ? 32'h1 : 32'h0);
    end
    next_cycle();
    clear_inputs();
    #1;
    check("mul_after_busy", 32'(bus.md_busy), 32'h0);
    check("mul_cycles", 32'(bus.stall_cycles), 32'd3);

    // Load-use on read port 2, register 5.
    next_cycle();
    set_load(5'd5, 5'd5);
    #1;
    check("lu_stall", 32'(bus.stall), 32'h07);
    check("lu_bubble", 32'(bus.ex_bubble), 32'h1);
    check("lu_busy", 32'(bus.md_busy), 32'h0);
    // Register 0 never stalls.
    next_cycle();
    set_load(5'd0, 5'd0);
    #1;
    check("lu_r0_stall", 32'(bus.stall), 32'h0);
    check("lu_r0_bubble", 32'(bus.ex_bubble), 32'h0);
    // Matching address on port 1 but port disabled: no hazard.
    next_cycle();
    clear_inputs();
    bus.ex_load = 1'b1; bus.ex_write_reg_en = 1'b1; bus.ex_write_reg_addr = 5'd9;
    bus.id_read_addr_1 = 5'd9;
    #1;
    check("lu_noen_stall", 32'(bus.stall), 32'h0);
    // Port 1 enabled: hazard.
    bus.id_read_en_1 = 1'b1;
    #1;
    check("lu_p1_stall", 32'(bus.stall), 32'h07);
    // Flush beats load-use.
    bus.flush_req = 1'b1;
    #1;
    check("fl_lu_flush", 32'(bus.flush), 32'h1);
    check("fl_lu_stall", 32'(bus.stall), 32'h0);
    check("fl_lu_bubble", 32'(bus.ex_bubble), 32'h0);
    next_cycle();
    clear_inputs();
    #1;
    check("lu_cycles", 32'(bus.stall_cycles), 32'd4);

    // Divide: 33 stall cycles then md_done on cycle 34.
    for (int i = 1; i <= 34; i++) begin
      next_cycle();
      bus.ex_md_start = 1'b1;
      bus.ex_md_div   = 1'b1;
      #1;
      check($sformatf("div_stall_%0d", i), 32'(bus.stall), (i < 34) ? 32'h0F : 32'h0);
      check($sformatf("div_done_%0d", i), 32'(bus.md_done), (i == 34) ? 32'h1 : 32'h0);
      check($sformatf("div_busy_%0d", i), 32'(bus.md_busy), (i >= 2) ? 32'h1 : 32'h0);
    end
    next_cycle();
    clear_inputs();
    #1;
    check("div_after_busy", 32'(bus.md_busy), 32'h0);
    check("div_cycles", 32'(bus.stall_cycles), 32'd37);

    // Divide flushed in its 10th cycle.
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      bus.ex_md_start = 1'b1;
      bus.ex_md_div   = 1'b1;
      bus.flush_req   = (i == 10);
      #1;
      check($sformatf("dfl_stall_%0d", i), 32'(bus.stall), (i < 10) ? 32'h0F : 32'h0);
      check($sformatf("dfl_flush_%0d", i), 32'(bus.flush), (i == 10) ? 32'h1 : 32'h0);
      check($sformatf("dfl_done_%0d", i), 32'(bus.md_done), 32'h0);
    end
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      clear_inputs();
      #1;
      check($sformatf("dfl_post_busy_%0d", i), 32'(bus.md_busy), 32'h0);
      check($sformatf("dfl_post_done_%0d", i), 32'(bus.md_done), 32'h0);
    end
    check("dfl_cycles", 32'(bus.stall_cycles), 32'd46);

    // Reset pulsed between edges during a multiply.
    for (int i = 1; i <= 2; i++) begin
      next_cycle();
      bus.ex_md_start = 1'b1;
      bus.ex_md_div   = 1'b0;
    end
    next_cycle();
    check("mrst_busy_before", 32'(bus.md_busy), 32'h1);
    rst = 1'b1;
    #1;
    check("mrst_stall", 32'(bus.stall), 32'h0);
    check("mrst_busy", 32'(bus.md_busy), 32'h0);
    check("mrst_done", 32'(bus.md_done), 32'h0);
    check("mrst_cycles", 32'(bus.stall_cycles), 32'h0);
    clear_inputs();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      check($sformatf("mrst_post_done_%0d", i), 32'(bus.md_done), 32'h0);
      check($sformatf("mrst_post_busy_%0d", i), 32'(bus.md_busy), 32'h0);
    end

    // Held load-use hazard saturates the stall counter.
    next_cycle();
    set_load(5'd3, 5'd3);
    repeat (70000) @(posedge clk);
    next_cycle();
    check("sat_cycles", 32'(bus.stall_cycles), 32'hFFFF);
    check("sat_stall", 32'(bus.stall), 32'h07);
    next_cycle();
    check("sat_hold", 32'(bus.stall_cycles), 32'hFFFF);
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 4: total cycles a multiply instruction occupies EX; SHALL be >= 2.
REQ-002 Parameter DIV_CYCLES, default 34: total cycles a divide instruction occupies EX; SHALL be >= 2.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 id_read_en_1 / id_read_en_2  in  1 each  ID register read-port enables.
REQ-006 id_read_addr_1 / id_read_addr_2  in  5 each  ID register read addresses.
REQ-007 ex_load  in  1  instruction in EX is a load.
REQ-008 ex_write_reg_en  in  1  instruction in EX writes a register.
REQ-009 ex_write_reg_addr  in  5  destination register of the EX instruction.
REQ-010 ex_md_start  in  1  instruction in EX is a multiply/divide; held high while EX is held.
REQ-011 ex_md_div  in  1  1 = divide, 0 = multiply; valid with ex_md_start.
REQ-012 flush_req  in  1  exception/redirect flush request.
REQ-013 stall  out  6  per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-014 ex_bubble  out  1  EX loads a NOP on the next edge.
REQ-015 flush  out  1  clear IF/ID/EX pipeline registers on the next edge.
REQ-016 md_done  out  1  multiply/divide result valid in EX this cycle.
REQ-017 md_busy  out  1  FSM is in MD_BUSY.
REQ-018 stall_cycles  out  16  saturating count of cycles with stall[0] = 1.

Function
REQ-019 The FSM SHALL have two states: IDLE and MD_BUSY; the 6-bit down-counter cnt SHALL be internal.
REQ-020 Priority in every state SHALL be: flush_req > multiply/divide > load-use.
REQ-021 When flush_req = 1, the block SHALL drive flush = 1, stall = 0, ex_bubble = 0 and md_done = 0 in the same cycle; on the next edge the FSM SHALL go to IDLE and cnt SHALL go to 0 (any multiply/divide in progress is aborted).
REQ-022 In IDLE with ex_md_start = 1, the block SHALL drive stall = 6'b001111 combinationally, and on the edge go to MD_BUSY with cnt = (ex_md_div ? DIV_CYCLES : MULT_CYCLES) - 2.
REQ-023 In MD_BUSY with cnt != 0, the block SHALL drive stall = 6'b001111, decrement cnt every edge, and ignore ex_md_start.
REQ-024 In MD_BUSY with cnt = 0, the block SHALL drive md_done = 1 and stall = 0, and return to IDLE on the edge; the EX residency is exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-025 Load-use hazard = ex_load & ex_write_reg_en & (ex_write_reg_addr != 0) & ((id_read_en_1 & id_read_addr_1 == ex_write_reg_addr) | (id_read_en_2 & id_read_addr_2 == ex_write_reg_addr)).
REQ-026 In IDLE with no flush and no ex_md_start, a load-use hazard SHALL produce stall = 6'b000111 and ex_bubble = 1 combinationally for that cycle only, with no state change.
REQ-027 With no condition active, the block SHALL drive stall = 0, ex_bubble = 0, flush = 0 and md_done = 0.
REQ-028 md_busy SHALL equal (state == MD_BUSY).
REQ-029 stall_cycles SHALL increment on each edge where stall[0] = 1, SHALL saturate at 16'hFFFF, and SHALL clear only on reset.
REQ-030 A register-0 destination SHALL never cause a load-use stall.

Reset
REQ-031 While rst = 1, regardless of clk: state = IDLE, cnt = 0 and stall_cycles = 0; all outputs SHALL be 0.
REQ-032 A reset asserted during MD_BUSY SHALL abort the operation immediately and give no md_done.

Verification
REQ-033 Multiply with MULT_CYCLES = 4: ex_md_start = 1 and ex_md_div = 0 for 4 cycles -> stall = 001111 for 3 cycles, then md_done = 1 with stall = 0, then IDLE; stall_cycles = 3.
REQ-034 Divide: ex_md_div = 1 -> stall = 001111 for 33 cycles, md_done on the 34th cycle, md_busy high for cycles 2-34.
REQ-035 Load-use: ex_load = 1, ex_write_reg_en = 1, ex_write_reg_addr = 5, id_read_en_2 = 1, id_read_addr_2 = 5 -> stall = 000111 and ex_bubble = 1 for one cycle; repeat with address 0 -> no stall.
REQ-036 flush_req in the 10th cycle of a divide -> flush = 1 and stall = 0 that cycle, IDLE next cycle, md_done never asserted.
REQ-037 rst pulsed mid-multiply between clock edges -> all outputs 0 immediately; stall_cycles = 0.
REQ-038 Hold a load-use hazard for 70000 cycles -> stall_cycles saturates at 16'hFFFF.
